mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Sequences the multiply/divide unit (HI/LO) for the pipelined MIPS core. It accepts
//  MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, models the fixed latency with a busy counter,
//  commits HI/LO when the count ends, and raises the D-stage stall for MDU-class instrs.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (legal range 1..15)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (legal range 1..15)
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  reset     in   1   asynchronous, active-low reset
//  start     in   1   E-stage instr is an MDU op; sampled on posedge
//  op        in   3   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6/7 no-op
//  rs_val    in   32  forwarded rs operand (E stage)
//  rt_val    in   32  forwarded rt operand (E stage)
//  d_is_md   in   1   D-stage instr is MULT/DIV/MFHI/MFLO/MTHI/MTLO
//  hi_o      out  32  committed HI (read by MFHI in E)
//  lo_o      out  32  committed LO (read by MFLO in E)
//  busy      out  1   multiply/divide in progress
//  stall_o   out  1   freeze PC/F/D, bubble into E
// BEHAVIOUR
//  - reset low (any time, incl. mid-operation): hi_o=0, lo_o=0, busy=0, counter=0,
//    pending results=0; running op is aborted, never committed.
//  - States: IDLE (busy=0), RUN (busy=1). Counter cnt is 4 bits.
//  - IDLE, edge with start=1 and op 0..3: operands captured, result computed into
//    pend_hi/pend_lo, cnt<=MULT_CYCLES (op0/1) or DIV_CYCLES (op2/3), busy<=1 -> RUN.
//  - RUN, each edge: cnt<=cnt-1; at the edge where cnt==1: hi_o<=pend_hi,
//    lo_o<=pend_lo, busy<=0 -> IDLE. busy is high exactly N cycles; new HI/LO
//    visible the cycle busy drops (start at edge t -> commit at edge t+N).
//  - start while busy=1: ignored (stall_o guarantees it never happens legally).
//  - MTHI/MTLO (op4/5) in IDLE: hi_o<=rs_val / lo_o<=rs_val at that edge; no RUN.
//  - op 6/7 with start=1: no state change.
//  - MULT: signed 32x32->64, {pend_hi,pend_lo}=product. MULTU: unsigned.
//  - DIV: signed, quotient truncates toward zero -> pend_lo; remainder takes
//    dividend sign -> pend_hi. DIVU: unsigned.
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  - Divide by zero (op2/3, rt_val=0): full RUN timing, HI/LO left unchanged at commit.
//  - stall_o (combinational) = d_is_md & (busy | (start & op<=3)).
//  - hi_o/lo_o are registered; no bypass of pending values.
// TESTING
//  - reset low mid-RUN of DIV (cnt=4) -> busy=0, hi_o=lo_o=0 at once; release, no commit ever.
//  - MULT rs=0xFFFFFFFE rt=3 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA; MULTU same
//    operands -> hi=0x00000002 lo=0xFFFFFFFA.
//  - DIV rs=-7 rt=2 -> busy 10 cycles, lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1); DIVU 7/2 -> lo=3 hi=1.
//  - DIV by 0 with hi=0x11,lo=0x22 -> busy 10 cycles, hi/lo stay 0x11/0x22;
//    DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
//  - MULT then d_is_md=1 every cycle -> stall_o=1 on start cycle + 5 busy cycles, 0 after;
//    second start during busy -> ignored, hi/lo from first op only.
//  - MTHI rs=0xDEADBEEF in IDLE -> hi_o=0xDEADBEEF next cycle, busy stays 0, lo unchanged.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Handshake and result bundle between the E stage and the multiply/divide sequencer.
// The E stage is the master; mdu_ctrl is the slave.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;
    logic        stall_o;

    modport master (
        output start, op, rs_val, rt_val, d_is_md,
        input  hi_o, lo_o, busy, stall_o
    );

    modport slave (
        input  start, op, rs_val, rt_val, d_is_md,
        output hi_o, lo_o, busy, stall_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// HI/LO sequencer for the MIPS multiply/divide unit: computes the result on issue,
// holds it pending for a fixed busy count, then commits it to HI/LO.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_ctrl_if.slave bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_skip;
    logic        r_busy;

    // Even op codes (MULT, DIV) are signed; odd ones (MULTU, DIVU) are unsigned.
    logic        w_signed;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_div;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_signed = ~bus.op[0];
    assign w_a64    = w_signed ? {{32{bus.rs_val[31]}}, bus.rs_val} : {32'd0, bus.rs_val};
    assign w_b64    = w_signed ? {{32{bus.rt_val[31]}}, bus.rt_val} : {32'd0, bus.rt_val};
    assign w_prod   = w_a64 * w_b64;

    // Sign-magnitude divide: truncation toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    assign w_a_neg  = w_signed & bus.rs_val[31];
    assign w_b_neg  = w_signed & bus.rt_val[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
    assign w_b_mag  = w_b_neg ? (32'd0 - bus.rt_val) : bus.rt_val;
    assign w_b_div  = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_div;
    assign w_r_mag  = w_a_mag % w_b_div;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // Issue/count/commit state machine; reset aborts any running operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_skip    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'd0, 3'd1: begin
                                r_pend_hi <= w_prod[63:32];
                                r_pend_lo <= w_prod[31:0];
                                r_skip    <= 1'b0;
                                r_cnt     <= 4'(MULT_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= S_RUN;
                            end
                            3'd2, 3'd3: begin
                                r_pend_hi <= w_rem;
                                r_pend_lo <= w_quot;
                                r_skip    <= (bus.rt_val == 32'd0);
                                r_cnt     <= 4'(DIV_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= S_RUN;
                            end
                            3'd4:    r_hi <= bus.rs_val;
                            3'd5:    r_lo <= bus.rs_val;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        // Divide by zero runs the full latency but leaves HI/LO alone.
                        if (!r_skip) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;
    assign bus.busy    = r_busy;
    assign bus.stall_o = bus.d_is_md & (r_busy | (bus.start & (bus.op <= 3'd3)));
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: scoreboard of expected HI/LO per issued operation.
module tb_mdu_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [63:0] sb[$];

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mult_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint unsigned pu;
        if (op == 3'd0) begin
            p = longint'(int'(a)) * longint'(int'(b));
            return 64'(p);
        end
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        return 64'(pu);
    endfunction

    function automatic logic [63:0] div_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int q;
        int r;
        if (op == 3'd2) begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int n_exp, input string name);
        int n;
        logic [63:0] want;
        sb.push_back(exp);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n !== n_exp) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d exp %0d", name, n, n_exp);
        end
        want = sb.pop_front();
        checks++;
        if ({bus.hi_o, bus.lo_o} !== want) begin
            errors++;
            $display("FAIL %s_hilo got %h_%h exp %h_%h", name, bus.hi_o, bus.lo_o, want[63:32], want[31:0]);
        end
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        logic [31:0] hi_prev;
        logic [31:0] lo_prev;
        hi_prev = bus.hi_o;
        lo_prev = bus.lo_o;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_val = v; bus.rt_val = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL mt_busy got %b exp 0", bus.busy);
        end
        checks++;
        if (op == 3'd4 && {bus.hi_o, bus.lo_o} !== {v, lo_prev}) begin
            errors++; $display("FAIL mthi got %h_%h exp %h_%h", bus.hi_o, bus.lo_o, v, lo_prev);
        end else if (op == 3'd5 && {bus.hi_o, bus.lo_o} !== {hi_prev, v}) begin
            errors++; $display("FAIL mtlo got %h_%h exp %h_%h", bus.hi_o, bus.lo_o, hi_prev, v);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.busy, bus.stall_o} !== 66'd0) begin
            errors++;
            $display("FAIL reset got hi=%h lo=%h busy=%b stall=%b exp all 0", bus.hi_o, bus.lo_o, bus.busy, bus.stall_o);
        end
    endtask

    task automatic test_mult();
        logic [31:0] a;
        logic [31:0] b;
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5, "mult");
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, 5, "multu");
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            issue(3'd0, a, b, mult_model(3'd0, a, b), 5, "mult_rand");
            issue(3'd1, a, b, mult_model(3'd1, a, b), 5, "multu_rand");
        end
    endtask

    task automatic test_div();
        logic [31:0] a;
        logic [31:0] b;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, "div");
        issue(3'd3, 32'd7, 32'd2, {32'd1, 32'd3}, 10, "divu");
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom_range(1, 100000);
            if (i == 1) b = 32'd0 - b;
            issue(3'd2, a, b, div_model(3'd2, a, b), 10, "div_rand");
            issue(3'd3, a, b, div_model(3'd3, a, b), 10, "divu_rand");
        end
    endtask

    task automatic test_div_special();
        mt(3'd4, 32'h11);
        mt(3'd5, 32'h22);
        issue(3'd2, 32'd1234, 32'd0, {32'h11, 32'h22}, 10, "div_by_zero");
        issue(3'd3, 32'd1234, 32'd0, {32'h11, 32'h22}, 10, "divu_by_zero");
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10, "div_overflow");
    endtask

    task automatic test_mthi();
        mt(3'd5, 32'h0BAD_F00D);
        mt(3'd4, 32'hDEAD_BEEF);
    endtask

    task automatic test_nop();
        logic [63:0] prev;
        prev = {bus.hi_o, bus.lo_o};
        @(negedge clk);
        bus.d_is_md = 1'b1; bus.start = 1'b1; bus.op = 3'd6; bus.rs_val = 32'h1; bus.rt_val = 32'h1;
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin
            errors++; $display("FAIL nop_stall got %b exp 0", bus.stall_o);
        end
        @(posedge clk); #1;
        bus.op = 3'd7;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.d_is_md = 1'b0;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.busy} !== {prev, 1'b0}) begin
            errors++; $display("FAIL nop_state got %h_%h busy=%b exp %h_%h busy=0", bus.hi_o, bus.lo_o, bus.busy, prev[63:32], prev[31:0]);
        end
    endtask

    task automatic test_stall_back_to_back();
        logic [63:0] want;
        sb.push_back(mult_model(3'd0, 32'd1000, 32'hFFFF_FFF0));
        @(negedge clk);
        bus.d_is_md = 1'b1; bus.start = 1'b1; bus.op = 3'd0; bus.rs_val = 32'd1000; bus.rt_val = 32'hFFFF_FFF0;
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin
            errors++; $display("FAIL stall_start got %b exp 1", bus.stall_o);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.stall_o, bus.busy} !== 2'b11) begin
                errors++; $display("FAIL stall_busy cycle %0d got stall=%b busy=%b exp 1 1", i, bus.stall_o, bus.busy);
            end
            if (i == 2) begin
                @(negedge clk);
                bus.start = 1'b1; bus.op = 3'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if ({bus.stall_o, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL stall_after got stall=%b busy=%b exp 0 0", bus.stall_o, bus.busy);
        end
        want = sb.pop_front();
        checks++;
        if ({bus.hi_o, bus.lo_o} !== want) begin
            errors++; $display("FAIL ignored_start got %h_%h exp %h_%h", bus.hi_o, bus.lo_o, want[63:32], want[31:0]);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.busy} !== {want, 1'b0}) begin
            errors++; $display("FAIL ignored_late got %h_%h busy=%b exp %h_%h", bus.hi_o, bus.lo_o, bus.busy, want[63:32], want[31:0]);
        end
        bus.d_is_md = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        mt(3'd4, 32'hAAAA_AAAA);
        mt(3'd5, 32'h5555_5555);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.rs_val = 32'd99; bus.rt_val = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL midrun_busy got %b exp 1", bus.busy);
        end
        reset = 1'b0;
        #2;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.busy} !== 65'd0) begin
            errors++; $display("FAIL midrun_reset got %h_%h busy=%b exp 0_0 busy=0", bus.hi_o, bus.lo_o, bus.busy);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.busy} !== 65'd0) begin
            errors++; $display("FAIL midrun_no_commit got %h_%h busy=%b exp 0_0 busy=0", bus.hi_o, bus.lo_o, bus.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 3'd7; bus.rs_val = 32'd0; bus.rt_val = 32'd0; bus.d_is_md = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        test_reset();
        test_mult();
        test_div();
        test_div_special();
        test_mthi();
        test_nop();
        test_stall_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
